// File: rtl/bf_level1_seq.sv
// bf_level1_seq
// Level-1 compare-unit input stage for the Bellman-Ford array. It latches a
// full window bus on start, then walks an internal phase counter over
// overlapping 4-word windows and emits one beat per phase on a valid/ready
// port. Each beat carries the raw window A,B,C,D plus min(sat(A+B), sat(C+D)).
// The beat for the next phase is computed combinationally from the operand
// register (or straight from win_i on the accepting edge) and loaded into
// the output register on the handshake edge, so there are no bubbles.

module bf_level1_seq #(
  parameter  int DATA_W     = 32,
  parameter  int NUM_PHASES = 2,
  localparam int PH_W       = $clog2(NUM_PHASES > 1 ? NUM_PHASES : 2)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [2*(NUM_PHASES+1)*DATA_W-1:0]    win_i,
  output logic                                  busy_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [DATA_W-1:0]                     a_o,
  output logic [DATA_W-1:0]                     b_o,
  output logic [DATA_W-1:0]                     c_o,
  output logic [DATA_W-1:0]                     d_o,
  output logic [DATA_W-1:0]                     min_o,
  output logic                                  sel_o,
  output logic [PH_W-1:0]                       phase_o,
  output logic                                  last_o,
  output logic                                  done_o
);

  localparam int NUM_WORDS = 2 * (NUM_PHASES + 1);
  localparam int BUS_W     = NUM_WORDS * DATA_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Saturating add: a carry out of the data width clamps to all-ones (INF),
  // so INF plus anything stays INF.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] sum_v;
    sum_v = {1'b0, x} + {1'b0, y};
    if (sum_v[DATA_W]) begin
      sat_add = {DATA_W{1'b1}};
    end else begin
      sat_add = sum_v[DATA_W-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  logic [1:0]        state_r;
  logic [BUS_W-1:0]  ops_r;
  logic [PH_W-1:0]   phase_r;
  logic              busy_r;
  logic              valid_r;
  logic              done_r;
  logic              last_r;
  logic              sel_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] c_r;
  logic [DATA_W-1:0] d_r;
  logic [DATA_W-1:0] min_r;

  // ---------------------------------------------------------------------
  // Next-beat datapath
  // ---------------------------------------------------------------------
  logic              accept_s;
  logic              hs_s;
  logic [BUS_W-1:0]  src_bus_s;
  logic [DATA_W-1:0] src_words_s [NUM_WORDS];
  logic [PH_W-1:0]   nxt_ph_s;
  logic [IDX_W-1:0]  base_idx_s;
  logic [DATA_W-1:0] nxt_a_s;
  logic [DATA_W-1:0] nxt_b_s;
  logic [DATA_W-1:0] nxt_c_s;
  logic [DATA_W-1:0] nxt_d_s;
  logic [DATA_W-1:0] sum_ab_s;
  logic [DATA_W-1:0] sum_cd_s;
  logic [DATA_W-1:0] nxt_min_s;
  logic              nxt_sel_s;
  logic              nxt_last_s;

  // Start is only honoured outside RUN, i.e. whenever busy_o is low.
  assign accept_s = start_i & (state_r != ST_RUN);
  assign hs_s     = valid_r & out_ready_i;

  // On the accepting edge the operand register is not loaded yet, so the
  // first beat is taken directly from win_i; afterwards from the register.
  assign src_bus_s = accept_s ? win_i : ops_r;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_words
    assign src_words_s[k] = src_bus_s[k*DATA_W +: DATA_W];
  end

  // Phase of the beat that the next load would present; holds at the last
  // phase so the window index never runs past the bus.
  always_comb begin
    nxt_ph_s = phase_r;
    if (accept_s) begin
      nxt_ph_s = {PH_W{1'b0}};
    end else if (phase_r != LAST_PH) begin
      nxt_ph_s = phase_r + PH_W'(1'b1);
    end else begin
      nxt_ph_s = phase_r;
    end
  end

  // Window p starts at word 2p; adjacent windows share two words.
  assign base_idx_s = IDX_W'({nxt_ph_s, 1'b0});
  assign nxt_a_s    = src_words_s[base_idx_s];
  assign nxt_b_s    = src_words_s[base_idx_s + IDX_W'(2'd1)];
  assign nxt_c_s    = src_words_s[base_idx_s + IDX_W'(2'd2)];
  assign nxt_d_s    = src_words_s[base_idx_s + IDX_W'(2'd3)];
  assign sum_ab_s   = sat_add(nxt_a_s, nxt_b_s);
  assign sum_cd_s   = sat_add(nxt_c_s, nxt_d_s);
  assign nxt_last_s = (nxt_ph_s == LAST_PH);

  // Relaxation compare: C+D only wins when strictly smaller; ties keep A+B.
  always_comb begin
    nxt_sel_s = 1'b0;
    nxt_min_s = sum_ab_s;
    if (sum_cd_s < sum_ab_s) begin
      nxt_sel_s = 1'b1;
      nxt_min_s = sum_cd_s;
    end else begin
      nxt_sel_s = 1'b0;
      nxt_min_s = sum_ab_s;
    end
  end

  // Sweep FSM plus operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ops_r   <= {BUS_W{1'b0}};
      phase_r <= {PH_W{1'b0}};
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      last_r  <= 1'b0;
      sel_r   <= 1'b0;
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      c_r     <= {DATA_W{1'b0}};
      d_r     <= {DATA_W{1'b0}};
      min_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start_i) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            ops_r   <= win_i;
            phase_r <= nxt_ph_s;
            valid_r <= 1'b1;
            a_r     <= nxt_a_s;
            b_r     <= nxt_b_s;
            c_r     <= nxt_c_s;
            d_r     <= nxt_d_s;
            min_r   <= nxt_min_s;
            sel_r   <= nxt_sel_s;
            last_r  <= nxt_last_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            if (phase_r == LAST_PH) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              phase_r <= nxt_ph_s;
              a_r     <= nxt_a_s;
              b_r     <= nxt_b_s;
              c_r     <= nxt_c_s;
              d_r     <= nxt_d_s;
              min_r   <= nxt_min_s;
              sel_r   <= nxt_sel_s;
              last_r  <= nxt_last_s;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          done_r  <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_r;
  assign out_valid_o = valid_r;
  assign done_o      = done_r;
  assign last_o      = last_r;
  assign sel_o       = sel_r;
  assign phase_o     = phase_r;
  assign a_o         = a_r;
  assign b_o         = b_r;
  assign c_o         = c_r;
  assign d_o         = d_r;
  assign min_o       = min_r;

  bf_level1_seq_chk #(
    .DATA_W (DATA_W),
    .PH_W   (PH_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy_o      (busy_r),
    .out_valid_o (valid_r),
    .out_ready_i (out_ready_i),
    .a_o         (a_r),
    .b_o         (b_r),
    .c_o         (c_r),
    .d_o         (d_r),
    .min_o       (min_r),
    .sel_o       (sel_r),
    .phase_o     (phase_r),
    .last_o      (last_r),
    .done_o      (done_r)
  );

endmodule

// Protocol checker for the output port: pulse shape of done, hold under
// backpressure, and last only ever accompanying a valid beat.
module bf_level1_seq_chk #(
  parameter int DATA_W = 32,
  parameter int PH_W   = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              busy_o,
  input logic              out_valid_o,
  input logic              out_ready_i,
  input logic [DATA_W-1:0] a_o,
  input logic [DATA_W-1:0] b_o,
  input logic [DATA_W-1:0] c_o,
  input logic [DATA_W-1:0] d_o,
  input logic [DATA_W-1:0] min_o,
  input logic              sel_o,
  input logic [PH_W-1:0]   phase_o,
  input logic              last_o,
  input logic              done_o
);

  logic [5*DATA_W+PH_W+1:0] beat_s;
  assign beat_s = {a_o, b_o, c_o, d_o, min_o, sel_o, phase_o, last_o};

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done_o |=> !done_o);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy_o && done_o));

  a_last_valid: assert property (@(posedge clk) disable iff (!rst_n)
    last_o |-> out_valid_o);

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(beat_s)));

endmodule

// File: tb/tb_bf_level1_seq.sv
// Scoreboard bench for bf_level1_seq: stimulus pushes expected beats,
// monitors pop and compare on each output handshake.

module tb_bf_level1_seq;

  typedef struct {
    logic [31:0] a, b, c, d, mn;
    logic        sel;
    int          ph;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // NUM_PHASES = 2 (default) instance
  logic st2, rdy2, busy2, v2, sel2, last2, done2;
  logic [6*32-1:0] win2;
  logic [31:0] a2, b2, c2, d2, mn2;
  logic [0:0] ph2;
  // NUM_PHASES = 5 instance
  logic st5, rdy5, busy5, v5, sel5, last5, done5;
  logic [12*32-1:0] win5;
  logic [31:0] a5, b5, c5, d5, mn5;
  logic [2:0] ph5;
  // NUM_PHASES = 1 instance
  logic st1, rdy1, busy1, v1, sel1, last1, done1;
  logic [4*32-1:0] win1;
  logic [31:0] a1, b1, c1, d1, mn1;
  logic [0:0] ph1;

  bf_level1_seq #(.DATA_W(32), .NUM_PHASES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(st2), .win_i(win2), .busy_o(busy2),
    .out_valid_o(v2), .out_ready_i(rdy2), .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2),
    .min_o(mn2), .sel_o(sel2), .phase_o(ph2), .last_o(last2), .done_o(done2));

  bf_level1_seq #(.DATA_W(32), .NUM_PHASES(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(st5), .win_i(win5), .busy_o(busy5),
    .out_valid_o(v5), .out_ready_i(rdy5), .a_o(a5), .b_o(b5), .c_o(c5), .d_o(d5),
    .min_o(mn5), .sel_o(sel5), .phase_o(ph5), .last_o(last5), .done_o(done5));

  bf_level1_seq #(.DATA_W(32), .NUM_PHASES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(st1), .win_i(win1), .busy_o(busy1),
    .out_valid_o(v1), .out_ready_i(rdy1), .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
    .min_o(mn1), .sel_o(sel1), .phase_o(ph1), .last_o(last1), .done_o(done1));

  int n_cmp = 0;
  int n_bad = 0;
  beat_t q2[$];
  beat_t q5[$];
  beat_t q1[$];
  logic rand_rdy = 1'b0;
  logic [31:0] vec[$];
  int cyc;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_sat(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic beat_t m_beat(input logic [31:0] w[$], input int p, input int n);
    beat_t e;
    logic [31:0] ab, cd;
    e.a = w[2*p]; e.b = w[2*p+1]; e.c = w[2*p+2]; e.d = w[2*p+3];
    ab = m_sat(e.a, e.b);
    cd = m_sat(e.c, e.d);
    e.sel  = (cd < ab);
    e.mn   = e.sel ? cd : ab;
    e.ph   = p;
    e.last = (p == n - 1);
    return e;
  endfunction

  function automatic beat_t mk(input logic [31:0] a, b, c, d, mn,
                               input logic sel, input int ph, input logic last);
    beat_t e;
    e.a = a; e.b = b; e.c = c; e.d = d; e.mn = mn; e.sel = sel; e.ph = ph; e.last = last;
    return e;
  endfunction

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string tag, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", tag, got, want);
    end
  endtask

  task automatic chki(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic chkz(input string tag, input logic [165:0] got);
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs %h, want all zero", tag, got);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t e,
                          input logic [31:0] a, b, c, d, mn,
                          input logic sel, input int ph, input logic last);
    n_cmp++;
    if ({a, b, c, d, mn, sel, last} !== {e.a, e.b, e.c, e.d, e.mn, e.sel, e.last} || ph != e.ph) begin
      n_bad++;
      $display("FAIL %s: got a=%h b=%h c=%h d=%h min=%h sel=%b ph=%0d last=%b, want a=%h b=%h c=%h d=%h min=%h sel=%b ph=%0d last=%b",
               tag, a, b, c, d, mn, sel, ph, last, e.a, e.b, e.c, e.d, e.mn, e.sel, e.ph, e.last);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon2
    beat_t e;
    logic pend_done, hold;
    logic [163:0] snap;
    pend_done = 1'b0; hold = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_done = 1'b0;
        hold = 1'b0;
      end else begin
        if (pend_done) begin
          chk1("done_after_last2", done2, 1'b1);
          chk1("busy_fall2", busy2, 1'b0);
          pend_done = 1'b0;
        end else if (done2) begin
          chk1("spurious_done2", done2, 1'b0);
        end
        if (hold) begin
          hold = 1'b0;
          n_cmp++;
          if ({v2, a2, b2, c2, d2, mn2, sel2, ph2, last2} !== snap) begin
            n_bad++;
            $display("FAIL hold2: got %h, want %h", {v2, a2, b2, c2, d2, mn2, sel2, ph2, last2}, snap);
          end
        end
        if (v2 && !rdy2) begin
          hold = 1'b1;
          snap = {v2, a2, b2, c2, d2, mn2, sel2, ph2, last2};
        end
        if (v2 && rdy2) begin
          if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_beat2: got beat ph=%0d, want none", ph2);
          end else begin
            e = q2.pop_front();
            chk_beat("beat2", e, a2, b2, c2, d2, mn2, sel2, ph2, last2);
            if (last2) pend_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : mon5
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && v5 && rdy5) begin
        if (q5.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat5: got beat ph=%0d, want none", ph5);
        end else begin
          e = q5.pop_front();
          chk_beat("beat5", e, a5, b5, c5, d5, mn5, sel5, ph5, last5);
        end
      end
    end
  end

  initial begin : mon1
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && v1 && rdy1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat1: got beat ph=%0d, want none", ph1);
        end else begin
          e = q1.pop_front();
          chk_beat("beat1", e, a1, b1, c1, d1, mn1, sel1, ph1, last1);
        end
      end
    end
  end

  // Ready driver for the parametrised instances.
  initial begin : rdy_drv
    rdy5 = 1'b1; rdy1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy5 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy1 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic start2(input logic [31:0] w0, w1, w2, w3, w4, w5);
    int g;
    g = 0;
    while (busy2 && g < 100) begin @(posedge clk); #1; g++; end
    if (busy2) chk1("start2_timeout", busy2, 1'b0);
    win2 = {w5, w4, w3, w2, w1, w0};
    st2 = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0;
    win2 = {6{32'hDEAD_BEEF}};
    chk1("busy_after_start2", busy2, 1'b1);
    chk1("first_valid_latency2", v2, 1'b1);
  endtask

  task automatic wait_done2(output int n);
    int g;
    g = 0;
    while (!done2 && g < 100) begin @(posedge clk); #1; g++; end
    chk1("done_seen2", done2, 1'b1);
    n = g;
  endtask

  task automatic run5(input logic [31:0] w[$]);
    int g;
    g = 0;
    while (busy5 && g < 400) begin @(posedge clk); #1; g++; end
    for (int k = 0; k < 12; k++) win5[k*32 +: 32] = w[k];
    for (int p = 0; p < 5; p++) q5.push_back(m_beat(w, p, 5));
    st5 = 1'b1;
    @(posedge clk); #1;
    st5 = 1'b0;
    win5 = '1;
    g = 0;
    while (!done5 && g < 400) begin @(posedge clk); #1; g++; end
    chk1("done_seen5", done5, 1'b1);
  endtask

  task automatic run1(input logic [31:0] w[$]);
    int g;
    g = 0;
    while (busy1 && g < 400) begin @(posedge clk); #1; g++; end
    for (int k = 0; k < 4; k++) win1[k*32 +: 32] = w[k];
    q1.push_back(m_beat(w, 0, 1));
    st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    win1 = '1;
    g = 0;
    while (!done1 && g < 400) begin @(posedge clk); #1; g++; end
    chk1("done_seen1", done1, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    rst_n = 1'b0;
    st2 = 1'b0; st5 = 1'b0; st1 = 1'b0;
    rdy2 = 1'b1;
    win2 = '0; win5 = '0; win1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chkz("reset_state2", {busy2, v2, done2, last2, sel2, ph2, a2, b2, c2, d2, mn2});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic sweep
    q2.push_back(mk(32'd5, 32'd3, 32'd10, 32'd1, 32'd8, 1'b0, 0, 1'b0));
    q2.push_back(mk(32'd10, 32'd1, 32'd2, 32'd7, 32'd9, 1'b1, 1, 1'b1));
    start2(32'd5, 32'd3, 32'd10, 32'd1, 32'd2, 32'd7);
    wait_done2(cyc);
    chki("sweep_len2", cyc, 2);

    // Saturation / tie, started in the done cycle
    q2.push_back(mk(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0));
    q2.push_back(mk(32'hFFFF_FFFF, 32'h0, 32'd1, 32'd2, 32'd3, 1'b1, 1, 1'b1));
    start2(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'd2);
    wait_done2(cyc);
    chki("sweep_len_b2b", cyc, 2);

    // Backpressure: ready low for three cycles during phase 0
    rdy2 = 1'b0;
    q2.push_back(mk(32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 1'b0, 0, 1'b0));
    q2.push_back(mk(32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 1'b0, 1, 1'b1));
    start2(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
    repeat (3) begin @(posedge clk); #1; end
    chk1("bp_valid_held", v2, 1'b1);
    chki("bp_phase_held", ph2, 0);
    rdy2 = 1'b1;
    @(posedge clk); #1;
    chki("bp_next_phase", ph2, 1);
    wait_done2(cyc);

    // Start while busy is ignored
    rdy2 = 1'b0;
    q2.push_back(mk(32'd100, 32'd200, 32'd50, 32'd60, 32'd110, 1'b1, 0, 1'b0));
    q2.push_back(mk(32'd50, 32'd60, 32'd7, 32'd8, 32'd15, 1'b1, 1, 1'b1));
    start2(32'd100, 32'd200, 32'd50, 32'd60, 32'd7, 32'd8);
    win2 = {6{32'd9}};
    st2 = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0;
    chk1("busy_during_ignored_start", busy2, 1'b1);
    rdy2 = 1'b1;
    wait_done2(cyc);

    // Reset mid-sweep during a phase-0 hold
    rdy2 = 1'b0;
    q2.push_back(mk(32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 1'b0, 0, 1'b0));
    q2.push_back(mk(32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 1'b0, 1, 1'b1));
    start2(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q2.delete();
    #1;
    chkz("reset_mid_sweep2", {busy2, v2, done2, last2, sel2, ph2, a2, b2, c2, d2, mn2});
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy2 = 1'b1;
    q2.push_back(mk(32'd5, 32'd3, 32'd10, 32'd1, 32'd8, 1'b0, 0, 1'b0));
    q2.push_back(mk(32'd10, 32'd1, 32'd2, 32'd7, 32'd9, 1'b1, 1, 1'b1));
    start2(32'd5, 32'd3, 32'd10, 32'd1, 32'd2, 32'd7);
    wait_done2(cyc);
    chki("sweep_len_after_reset", cyc, 2);

    // Parametrised instances, random words incl. INF, random ready
    rand_rdy = 1'b1;
    repeat (3) begin
      vec.delete();
      for (int k = 0; k < 12; k++) vec.push_back(rword());
      run5(vec);
    end
    repeat (3) begin
      vec.delete();
      for (int k = 0; k < 4; k++) vec.push_back(rword());
      run1(vec);
    end
    rand_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chki("q2_drained", q2.size(), 0);
    chki("q5_drained", q5.size(), 0);
    chki("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
